// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU external bus path.
// Arbiter state, response owner and the full-word byte mask.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } typeArbState;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } typeArbOwner;

    localparam logic [3:0] BYTEENABLE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Fetch, data and Avalon master signals of the bus arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mips_cpu_bus_arbiter_if;

    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        i_readvalid;

    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        d_readvalid;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport slave (
        input  i_address, i_read,
        output i_waitrequest, i_readdata, i_readvalid,
        input  d_address, d_read, d_write,
        input  d_writedata, d_byteenable,
        output d_waitrequest, d_readdata, d_readvalid,
        output address, read, write,
        output writedata, byteenable,
        input  waitrequest, readdata
    );

    modport master (
        output i_address, i_read,
        input  i_waitrequest, i_readdata, i_readvalid,
        output d_address, d_read, d_write,
        output d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata, d_readvalid,
        input  address, read, write,
        input  writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-MM bus between instruction fetch and load/store.
// Data has priority; a bounded streak of data grants lets fetch through.
module mips_cpu_bus_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    mips_cpu_bus_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typeArbState state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        resp_pending_q, resp_pending_d;
    typeArbOwner resp_owner_q, resp_owner_d;

    logic d_pend;
    logic d_rd_op;
    logic grant_i;
    logic grant_d;
    logic done_i;
    logic done_d;

    assign d_pend  = bus.d_read | bus.d_write;
    assign d_rd_op = bus.d_read & ~bus.d_write;
    assign grant_i = (state_q == GRANT_I);
    assign grant_d = (state_q == GRANT_D);
    assign done_i  = grant_i & bus.i_read & ~bus.waitrequest;
    assign done_d  = grant_d & d_rd_op & ~bus.waitrequest;

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            grant_i: begin
                if (!bus.i_read || !bus.waitrequest)
                    state_d = IDLE;
            end
            grant_d: begin
                if (!d_pend || !bus.waitrequest)
                    state_d = IDLE;
            end
            default: begin
                if (d_pend && !(bus.i_read && starve_q == LIMIT))
                    state_d = GRANT_D;
                else if (bus.i_read)
                    state_d = GRANT_I;
            end
        endcase
    end

    // Counts only data grants that overtook a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (!bus.i_read)
            starve_d = '0;
        else if (state_q == IDLE && state_d == GRANT_I)
            starve_d = '0;
        else if (state_q == IDLE && state_d == GRANT_D
                 && starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
    end

    always_comb begin
        resp_pending_d = done_i | done_d;
        resp_owner_d   = resp_owner_q;
        if (done_d)
            resp_owner_d = OWNER_D;
        else if (done_i)
            resp_owner_d = OWNER_I;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= OWNER_I;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
        end
    end

    always_comb begin
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        unique case (1'b1)
            grant_i: begin
                bus.address    = bus.i_address;
                bus.read       = bus.i_read;
                bus.byteenable = BYTEENABLE_WORD;
            end
            grant_d: begin
                bus.address    = bus.d_address;
                bus.read       = d_rd_op;
                bus.write      = bus.d_write;
                bus.writedata  = bus.d_writedata;
                bus.byteenable = bus.d_byteenable;
            end
            default: ;
        endcase
    end

    assign bus.i_waitrequest = ~(grant_i & ~bus.waitrequest);
    assign bus.d_waitrequest = ~(grant_d & ~bus.waitrequest);

    assign bus.i_readvalid = resp_pending_q & (resp_owner_q == OWNER_I);
    assign bus.d_readvalid = resp_pending_q & (resp_owner_q == OWNER_D);
    assign bus.i_readdata  = bus.i_readvalid ? bus.readdata : '0;
    assign bus.d_readdata  = bus.d_readvalid ? bus.readdata : '0;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed scenarios plus random requester/memory traffic
// checked against a transaction-level scoreboard.
module tb_mips_cpu_bus_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_cpu_bus_arbiter_if bus();

    mips_cpu_bus_arbiter #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic        exp_rv_i, exp_rv_d;
    logic [31:0] exp_dat_i, exp_dat_d;
    logic        i_done, d_done;
    int          streak, i_age, max_age, n_gnt;
    byte         gnt_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic clr();
        bus.i_address    = '0;
        bus.i_read       = 1'b0;
        bus.d_address    = '0;
        bus.d_read       = 1'b0;
        bus.d_write      = 1'b0;
        bus.d_writedata  = '0;
        bus.d_byteenable = '0;
        bus.waitrequest  = 1'b0;
        bus.readdata     = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_addr"}, bus.address, 32'h0);
        chk({tag, "_rd"}, {31'h0, bus.read}, 32'h0);
        chk({tag, "_wr"}, {31'h0, bus.write}, 32'h0);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        mid();
        chk_idle_bus("rst");
        chk("rst_wdata", bus.writedata, 32'h0);
        chk("rst_be", {28'h0, bus.byteenable}, 32'h0);
        chk("rst_iwait", {31'h0, bus.i_waitrequest}, 32'h1);
        chk("rst_dwait", {31'h0, bus.d_waitrequest}, 32'h1);
        chk("rst_irv", {31'h0, bus.i_readvalid}, 32'h0);
        chk("rst_drv", {31'h0, bus.d_readvalid}, 32'h0);
        chk("rst_ird", bus.i_readdata, 32'h0);
        chk("rst_drd", bus.d_readdata, 32'h0);
        rst_n = 1'b1;

        // single fetch, zero wait
        cyc();
        bus.i_read = 1'b1;
        bus.i_address = 32'hBFC0_0000;
        mid();
        chk_idle_bus("f_n");
        cyc();
        mid();
        chk("f_rd", {31'h0, bus.read}, 32'h1);
        chk("f_addr", bus.address, 32'hBFC0_0000);
        chk("f_wr", {31'h0, bus.write}, 32'h0);
        chk("f_be", {28'h0, bus.byteenable}, 32'hF);
        chk("f_iwait", {31'h0, bus.i_waitrequest}, 32'h0);
        chk("f_dwait", {31'h0, bus.d_waitrequest}, 32'h1);
        cyc();
        bus.i_read = 1'b0;
        bus.readdata = 32'h2402_0005;
        mid();
        chk("f_irv", {31'h0, bus.i_readvalid}, 32'h1);
        chk("f_ird", bus.i_readdata, 32'h2402_0005);
        chk("f_drv", {31'h0, bus.d_readvalid}, 32'h0);
        chk("f_drd", bus.d_readdata, 32'h0);
        cyc();
        mid();
        chk("f_irv_end", {31'h0, bus.i_readvalid}, 32'h0);

        // simultaneous fetch and data write
        cyc();
        bus.i_read = 1'b1;
        bus.i_address = 32'hBFC0_0004;
        bus.d_write = 1'b1;
        bus.d_address = 32'h0000_1000;
        bus.d_writedata = 32'hDEAD_BEEF;
        bus.d_byteenable = 4'b1111;
        mid();
        cyc();
        mid();
        chk("p_wr", {31'h0, bus.write}, 32'h1);
        chk("p_rd", {31'h0, bus.read}, 32'h0);
        chk("p_wdata", bus.writedata, 32'hDEAD_BEEF);
        chk("p_addr", bus.address, 32'h0000_1000);
        chk("p_iwait", {31'h0, bus.i_waitrequest}, 32'h1);
        chk("p_dwait", {31'h0, bus.d_waitrequest}, 32'h0);
        cyc();
        bus.d_write = 1'b0;
        mid();
        chk_idle_bus("p_bub");
        chk("p_bub_iwait", {31'h0, bus.i_waitrequest}, 32'h1);
        chk("p_bub_drv", {31'h0, bus.d_readvalid}, 32'h0);
        cyc();
        mid();
        chk("p_i_rd", {31'h0, bus.read}, 32'h1);
        chk("p_i_addr", bus.address, 32'hBFC0_0004);
        chk("p_i_iwait", {31'h0, bus.i_waitrequest}, 32'h0);
        cyc();
        bus.i_read = 1'b0;
        bus.readdata = 32'h1234_5678;
        mid();
        chk("p_irv", {31'h0, bus.i_readvalid}, 32'h1);
        chk("p_ird", bus.i_readdata, 32'h1234_5678);

        // data read stalled three cycles
        cyc();
        bus.d_read = 1'b1;
        bus.d_address = 32'h0000_2000;
        bus.d_byteenable = 4'b0011;
        bus.waitrequest = 1'b1;
        mid();
        cyc();
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("s_rd", {31'h0, bus.read}, 32'h1);
            chk("s_addr", bus.address, 32'h0000_2000);
            chk("s_be", {28'h0, bus.byteenable}, 32'h3);
            chk("s_dwait", {31'h0, bus.d_waitrequest}, 32'h1);
            chk("s_drv", {31'h0, bus.d_readvalid}, 32'h0);
            cyc();
        end
        bus.waitrequest = 1'b0;
        mid();
        chk("s4_rd", {31'h0, bus.read}, 32'h1);
        chk("s4_addr", bus.address, 32'h0000_2000);
        chk("s4_dwait", {31'h0, bus.d_waitrequest}, 32'h0);
        cyc();
        bus.d_read = 1'b0;
        bus.readdata = 32'hCAFE_F00D;
        mid();
        chk("s_drv1", {31'h0, bus.d_readvalid}, 32'h1);
        chk("s_drd", bus.d_readdata, 32'hCAFE_F00D);
        chk("s_irv", {31'h0, bus.i_readvalid}, 32'h0);
        cyc();
        mid();
        chk("s_drv2", {31'h0, bus.d_readvalid}, 32'h0);

        // starvation limit under continuous requests
        cyc();
        bus.i_read = 1'b1;
        bus.i_address = 32'hBFC0_0100;
        bus.d_read = 1'b1;
        bus.d_address = 32'h0000_3000;
        gnt_q.delete();
        for (int c = 0; c < 30; c++) begin
            mid();
            if (!bus.i_waitrequest) gnt_q.push_back(8'h49);
            if (!bus.d_waitrequest) gnt_q.push_back(8'h44);
            cyc();
        end
        chk("sv_count", gnt_q.size(), 32'd15);
        for (int k = 0; k < gnt_q.size(); k++)
            chk($sformatf("sv_gnt%0d", k), {24'h0, gnt_q[k]},
                (k % (LIMIT + 1) == LIMIT) ? 32'h49 : 32'h44);
        clr();
        cyc();
        cyc();

        // read and write together is a write
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        bus.d_address = 32'h0000_4000;
        bus.d_writedata = 32'h0BAD_CAFE;
        bus.d_byteenable = 4'b1100;
        mid();
        cyc();
        mid();
        chk("rw_wr", {31'h0, bus.write}, 32'h1);
        chk("rw_rd", {31'h0, bus.read}, 32'h0);
        chk("rw_wdata", bus.writedata, 32'h0BAD_CAFE);
        chk("rw_dwait", {31'h0, bus.d_waitrequest}, 32'h0);
        cyc();
        clr();
        mid();
        chk("rw_drv1", {31'h0, bus.d_readvalid}, 32'h0);
        cyc();
        mid();
        chk("rw_drv2", {31'h0, bus.d_readvalid}, 32'h0);

        // reset during a stalled data grant
        cyc();
        bus.d_read = 1'b1;
        bus.d_address = 32'h0000_5000;
        bus.waitrequest = 1'b1;
        mid();
        cyc();
        mid();
        chk("r_rd_pre", {31'h0, bus.read}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle_bus("r_async");
        chk("r_dwait", {31'h0, bus.d_waitrequest}, 32'h1);
        cyc();
        clr();
        mid();
        rst_n = 1'b1;
        cyc();
        mid();
        chk("r_drv", {31'h0, bus.d_readvalid}, 32'h0);

        // reset in the response cycle drops the readvalid
        cyc();
        bus.d_read = 1'b1;
        bus.d_address = 32'h0000_6000;
        mid();
        cyc();
        mid();
        chk("rr_dwait", {31'h0, bus.d_waitrequest}, 32'h0);
        cyc();
        bus.d_read = 1'b0;
        bus.readdata = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        chk("rr_drv", {31'h0, bus.d_readvalid}, 32'h0);
        chk("rr_drd", bus.d_readdata, 32'h0);
        mid();
        rst_n = 1'b1;
        cyc();
        mid();
        chk("rr_drv2", {31'h0, bus.d_readvalid}, 32'h0);

        // normal arbitration after reset
        cyc();
        bus.d_read = 1'b1;
        bus.d_address = 32'h0000_7000;
        mid();
        cyc();
        mid();
        chk("ra_rd", {31'h0, bus.read}, 32'h1);
        chk("ra_addr", bus.address, 32'h0000_7000);
        cyc();
        bus.d_read = 1'b0;
        bus.readdata = 32'h0F0F_0F0F;
        mid();
        chk("ra_drv", {31'h0, bus.d_readvalid}, 32'h1);
        chk("ra_drd", bus.d_readdata, 32'h0F0F_0F0F);
        cyc();
        clr();

        // random traffic against the scoreboard
        exp_rv_i = 1'b0;
        exp_rv_d = 1'b0;
        exp_dat_i = '0;
        exp_dat_d = '0;
        i_done = 1'b0;
        d_done = 1'b0;
        streak = 0;
        i_age = 0;
        max_age = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.waitrequest = ($urandom_range(0, 3) == 0);
            if (exp_rv_i) bus.readdata = exp_dat_i;
            else if (exp_rv_d) bus.readdata = exp_dat_d;
            else bus.readdata = $urandom;
            if (!bus.i_read || i_done) begin
                bus.i_read = $urandom_range(0, 1) == 1;
                bus.i_address = {$urandom, 2'b00} >> 2 << 2;
            end
            if (!(bus.d_read | bus.d_write) || d_done) begin
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
                case ($urandom_range(0, 5))
                    0, 1: bus.d_read = 1'b1;
                    2, 3: bus.d_write = 1'b1;
                    4: begin
                        bus.d_read = 1'b1;
                        bus.d_write = 1'b1;
                    end
                    default: ;
                endcase
                bus.d_address = $urandom;
                bus.d_writedata = $urandom;
                bus.d_byteenable = 4'($urandom);
            end
            i_done = 1'b0;
            d_done = 1'b0;
            mid();
            chk("rnd_irv", {31'h0, bus.i_readvalid}, {31'h0, exp_rv_i});
            chk("rnd_ird", bus.i_readdata, exp_rv_i ? exp_dat_i : 32'h0);
            chk("rnd_drv", {31'h0, bus.d_readvalid}, {31'h0, exp_rv_d});
            chk("rnd_drd", bus.d_readdata, exp_rv_d ? exp_dat_d : 32'h0);
            exp_rv_i = 1'b0;
            exp_rv_d = 1'b0;
            if (bus.i_read) i_age++;
            if (!bus.i_waitrequest) begin
                chk("rnd_excl", {31'h0, bus.d_waitrequest}, 32'h1);
                chk("rnd_iaddr", bus.address, bus.i_address);
                chk("rnd_ird_cmd", {31'h0, bus.read}, 32'h1);
                chk("rnd_iwr_cmd", {31'h0, bus.write}, 32'h0);
                exp_rv_i = 1'b1;
                exp_dat_i = mem_word(bus.i_address);
                i_done = 1'b1;
                if (i_age > max_age) max_age = i_age;
                i_age = 0;
                streak = 0;
            end
            if (!bus.d_waitrequest) begin
                chk("rnd_daddr", bus.address, bus.d_address);
                chk("rnd_drd_cmd", {31'h0, bus.read},
                    {31'h0, bus.d_read & ~bus.d_write});
                chk("rnd_dwr_cmd", {31'h0, bus.write}, {31'h0, bus.d_write});
                chk("rnd_wdata", bus.writedata, bus.d_writedata);
                chk("rnd_be", {28'h0, bus.byteenable},
                    {28'h0, bus.d_byteenable});
                exp_rv_d = bus.d_read & ~bus.d_write;
                exp_dat_d = mem_word(bus.d_address);
                d_done = 1'b1;
                if (bus.i_read) begin
                    streak++;
                    chk("rnd_starve", {31'h0, streak <= LIMIT + 1}, 32'h1);
                end
            end
            cyc();
        end
        if (i_age > max_age) max_age = i_age;
        chk("rnd_fetch_age", {31'h0, max_age < 150}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Two-port Avalon-MM bus arbiter that shares the CPU's single external memory bus between the instruction-fetch requester and the load/store (data) requester. It sits between the `mips_cpu_bus` state machine and the top-level Avalon master ports. Each access gets a registered grant, and the grant is held across `waitrequest` stalls. Read data is routed back to the owning requester on the cycle after completion. Data accesses have priority, and a starvation limit guarantees fetch progress.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants allowed while a fetch is pending. Legal range is 1–15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it (0) immediately forces every register and output to its reset value.
- `i_address` in 32, `i_read` in 1: fetch request.
- `i_waitrequest` out 1, `i_readdata` out 32, `i_readvalid` out 1: fetch response.
- `d_address` in 32, `d_read` in 1, `d_write` in 1, `d_writedata` in 32, `d_byteenable` in 4: data request.
- `d_waitrequest` out 1, `d_readdata` out 32, `d_readvalid` out 1: data response.
- `address` out 32, `read` out 1, `write` out 1, `writedata` out 32, `byteenable` out 4: Avalon master outputs.
- `waitrequest` in 1, `readdata` in 32: Avalon master inputs. `readdata` is valid the cycle after read completion.

## Operation
- States:
  - IDLE: no bus command driven.
  - GRANT_I: fetch owns the bus.
  - GRANT_D: data owns the bus.
- Arbitration happens in IDLE only.
  - Data is pending when `d_read | d_write`; fetch is pending when `i_read`.
  - If both are pending and `starve_cnt == STARVE_LIMIT`, the next state is GRANT_I. Otherwise data wins.
  - If only one is pending, it wins. If neither is pending, stay in IDLE.
- While in GRANT_x:
  - The bus outputs mirror requester x.
  - For fetch: `write=0`, `writedata=0`, `byteenable=4'b1111`.
  - A completion occurs on any cycle with `waitrequest==0`. That cycle drives `x_waitrequest=0`, and the next state is IDLE (one bubble cycle between accesses).
  - On cycles with `waitrequest==1`, stay in GRANT_x and hold `x_waitrequest=1`.
- `x_waitrequest` is 1 whenever x is not granted or the bus is stalled.
- Both read and write asserted on the data port: the access is treated as a write, `read` is driven 0, and no readvalid is generated.
- Granted requester drops its request before completion:
  - Bus command goes to 0 that same cycle (combinational mirror).
  - Next state is IDLE, and no response is generated.
- Read response:
  - On read completion, register `resp_owner` (I or D) and `resp_pending=1`.
  - Next cycle: `x_readvalid=1` and `x_readdata=readdata` for the owner.
  - The non-owner's readdata is 0. Both readvalids are 0 otherwise.
- Starvation counter `starve_cnt`, 4 bits:
  - Increments (saturating at STARVE_LIMIT) on each IDLE→GRANT_D transition where `i_read==1`.
  - Clears on IDLE→GRANT_I, and on any cycle with `i_read==0`.

## Timing
- Reset values:
  - State IDLE, `starve_cnt=0`, `resp_pending=0`.
  - `address=0`, `read=0`, `write=0`, `writedata=0`, `byteenable=0`.
  - `i_waitrequest=1`, `d_waitrequest=1`.
  - Readvalids 0, readdatas 0.
- Latency:
  - Request seen in IDLE at cycle N → bus command at N+1.
  - Zero-wait completion at N+1, readvalid at N+2.
  - Best-case throughput is one access per 2 cycles.
- Grant is stable for the entire stall. Bus outputs change only on grant change or when the requester changes inputs.
- Bus outputs are combinational from the grant register plus the owner's inputs. There is no path from the non-owner's inputs to the bus.
- Reset asserted mid-transaction:
  - Bus command drops asynchronously.
  - Any pending readvalid is discarded and never emitted.
  - After reset deasserts, arbitration restarts from IDLE.
- A read response (`resp_pending`) may overlap a new IDLE decision. The two are independent.

## Structure
- Shared package `mips_cpu_pkg`:
  - `typeArbState` enum (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10).
  - `typeArbOwner` enum (OWNER_I, OWNER_D).
  - Constant `BYTEENABLE_WORD = 4'b1111`.
- Single module. The state register, counter and response register are too small to justify a sub-module.
- Expected RTL: ~150–250 lines.

## Test plan
- Reset then `i_read=1`, `i_address=32'hBFC00000`, `waitrequest=0`, `readdata=32'h24020005`:
  - `read=1` with that address at cycle 2.
  - `i_readvalid=1`, `i_readdata=32'h24020005` at cycle 3.
  - `d_readvalid` stays 0.
- Simultaneous `i_read` and `d_write` (`d_address=32'h00001000`, `d_writedata=32'hDEADBEEF`, `d_byteenable=4'b1111`):
  - Data is granted first: `write=1`, `writedata=32'hDEADBEEF`.
  - Fetch is granted after a one-cycle bubble.
  - `i_waitrequest` stays 1 throughout the data access.
- Data read with `waitrequest` held high for 3 cycles:
  - Grant and bus outputs are stable for all 4 cycles.
  - `d_waitrequest=0` only on the 4th cycle.
  - `d_readvalid` pulses once, one cycle later.
- STARVE_LIMIT=4, `i_read` and `d_read` continuously asserted:
  - Grant order is D,D,D,D,I,D,D,D,D,I…
  - `starve_cnt` clears after each I grant.
- Reset pulled low while in GRANT_D with `waitrequest=1`:
  - `read`, `write` and `address` are 0 immediately (before the next edge).
  - No readvalid is emitted.
  - Normal arbitration resumes after release.
- `d_read=1` and `d_write=1` together: bus shows `write=1`, `read=0`; no `d_readvalid` follows.
